// File: rtl/hdmi_pkg.sv
// Shared raster timing constants and helpers for the HDMI video path.
// Holds the 1080p60 defaults, a 4-pixel-aligned 720p60 alternate set and the region decode helper.
// No logic; imported by the timing counter and the video timing master.
package hdmi_pkg;

    localparam int LANES  = 4;   // pixels carried per clock
    localparam int PIX_W  = 24;  // {R,G,B} 8 bits each
    localparam int LANE_W = 64;  // upstream lane width, only [PIX_W-1:0] carries a pixel
    localparam int CNT_W  = 16;  // hc/vc counter width

    // 1080p60 (CEA-861 VIC 16)
    localparam int H_ACTIVE_1080P = 1920;
    localparam int H_FP_1080P     = 88;
    localparam int H_SYNC_1080P   = 44;
    localparam int H_BP_1080P     = 148;
    localparam int V_ACTIVE_1080P = 1080;
    localparam int V_FP_1080P     = 4;
    localparam int V_SYNC_1080P   = 5;
    localparam int V_BP_1080P     = 36;

    // 720p60 with the front porch widened 110 -> 112 so every H value divides by LANES;
    // the line grows from 1650 to 1652 pixels, which sinks tolerate.
    localparam int H_ACTIVE_720P  = 1280;
    localparam int H_FP_720P      = 112;
    localparam int H_SYNC_720P    = 40;
    localparam int H_BP_720P      = 220;
    localparam int V_ACTIVE_720P  = 720;
    localparam int V_FP_720P      = 5;
    localparam int V_SYNC_720P    = 5;
    localparam int V_BP_720P      = 20;

    // Order of regions along either axis.
    typedef enum logic [1:0] {
        REG_ACTIVE = 2'd0,
        REG_FP     = 2'd1,
        REG_SYNC   = 2'd2,
        REG_BP     = 2'd3
    } region_e;

    // Pixels -> beats.
    function automatic int beats(input int px);
        return px / LANES;
    endfunction

    // Classify a counter position given the exclusive end of each region.
    function automatic region_e region_of(input logic [CNT_W-1:0] pos,
                                          input logic [CNT_W-1:0] act_end,
                                          input logic [CNT_W-1:0] fp_end,
                                          input logic [CNT_W-1:0] sync_end);
        region_e r;
        if (pos < act_end)       r = REG_ACTIVE;
        else if (pos < fp_end)   r = REG_FP;
        else if (pos < sync_end) r = REG_SYNC;
        else                     r = REG_BP;
        return r;
    endfunction

endpackage

// File: rtl/hdmi_timing_counter.sv
// Free-running H/V raster counter (beats x lines) with per-axis region decode.
// Latency: counters are registers; region outputs are combinational from them.
// Backpressure: none, the raster never stalls.
// Ports: clk_i/rst_ni clock and async active-low reset; hc_o beat in line, vc_o line in frame;
//        h_region_o/v_region_o region of the current position on each axis.
module hdmi_timing_counter
    import hdmi_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_1080P,
    parameter int H_FP     = H_FP_1080P,
    parameter int H_SYNC   = H_SYNC_1080P,
    parameter int H_BP     = H_BP_1080P,
    parameter int V_ACTIVE = V_ACTIVE_1080P,
    parameter int V_FP     = V_FP_1080P,
    parameter int V_SYNC   = V_SYNC_1080P,
    parameter int V_BP     = V_BP_1080P
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    output logic [CNT_W-1:0] hc_o,
    output logic [CNT_W-1:0] vc_o,
    output region_e          h_region_o,
    output region_e          v_region_o
);

    localparam logic [CNT_W-1:0] H_ACT_END  = CNT_W'(beats(H_ACTIVE));
    localparam logic [CNT_W-1:0] H_FP_END   = CNT_W'(beats(H_ACTIVE + H_FP));
    localparam logic [CNT_W-1:0] H_SYNC_END = CNT_W'(beats(H_ACTIVE + H_FP + H_SYNC));
    localparam logic [CNT_W-1:0] H_LAST     = CNT_W'(beats(H_ACTIVE + H_FP + H_SYNC + H_BP) - 1);

    localparam logic [CNT_W-1:0] V_ACT_END  = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] V_FP_END   = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] V_SYNC_END = CNT_W'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [CNT_W-1:0] V_LAST     = CNT_W'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);

    logic [CNT_W-1:0] hc_q, hc_d;
    logic [CNT_W-1:0] vc_q, vc_d;

    always_comb begin
        hc_d = hc_q + 1'b1;
        vc_d = vc_q;
        if (hc_q == H_LAST) begin
            hc_d = '0;
            vc_d = (vc_q == V_LAST) ? '0 : vc_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            hc_q <= '0;
            vc_q <= '0;
        end else begin
            hc_q <= hc_d;
            vc_q <= vc_d;
        end
    end

    assign hc_o       = hc_q;
    assign vc_o       = vc_q;
    assign h_region_o = region_of(hc_q, H_ACT_END, H_FP_END, H_SYNC_END);
    assign v_region_o = region_of(vc_q, V_ACT_END, V_FP_END, V_SYNC_END);

endmodule

// File: rtl/hdmi_video_timing.sv
// Raster timing master: pulls 4-pixel beats during active video, drives pixels + de/hsync/vsync.
// Latency: counter position -> registered pixel/timing outputs is 1 clock.
// Backpressure: none toward the encoder; ready is raised only in active video and drain lines.
// Ports: clock/reset_n; video_width/height constants; start_frame pulse and ready/valid/bits_0..3
//        toward the pixel generator; pixel_0..3/de/hsync/vsync toward TMDS; clear_status,
//        underflow (sticky) and drop_count (saturating) status.
module hdmi_video_timing
    import hdmi_pkg::*;
#(
    parameter int H_ACTIVE  = H_ACTIVE_1080P,
    parameter int H_FP      = H_FP_1080P,
    parameter int H_SYNC    = H_SYNC_1080P,
    parameter int H_BP      = H_BP_1080P,
    parameter int V_ACTIVE  = V_ACTIVE_1080P,
    parameter int V_FP      = V_FP_1080P,
    parameter int V_SYNC    = V_SYNC_1080P,
    parameter int V_BP      = V_BP_1080P,
    parameter bit HSYNC_POL = 1'b1,
    parameter bit VSYNC_POL = 1'b1
) (
    input  logic              clock,
    input  logic              reset_n,
    output logic [15:0]       video_width,
    output logic [15:0]       video_height,
    output logic              start_frame,
    output logic              ready,
    input  logic              valid,
    input  logic [LANE_W-1:0] bits_0,
    input  logic [LANE_W-1:0] bits_1,
    input  logic [LANE_W-1:0] bits_2,
    input  logic [LANE_W-1:0] bits_3,
    output logic [PIX_W-1:0]  pixel_0,
    output logic [PIX_W-1:0]  pixel_1,
    output logic [PIX_W-1:0]  pixel_2,
    output logic [PIX_W-1:0]  pixel_3,
    output logic              de,
    output logic              hsync,
    output logic              vsync,
    input  logic              clear_status,
    output logic              underflow,
    output logic [15:0]       drop_count
);

    localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);

    logic [CNT_W-1:0] hc, vc;
    region_e          h_region, v_region;

    hdmi_timing_counter #(
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP)
    ) u_timing_counter (
        .clk_i      (clock),
        .rst_ni     (reset_n),
        .hc_o       (hc),
        .vc_o       (vc),
        .h_region_o (h_region),
        .v_region_o (v_region)
    );

    logic act;      // active video position: a beat is owed to the encoder
    logic drain;    // vertical blanking except the last line: flush leftover beats
    logic sof;      // one line before active: kick the pixel generator

    assign act   = (h_region == REG_ACTIVE) && (v_region == REG_ACTIVE);
    assign drain = (v_region != REG_ACTIVE) && (vc != V_LAST);
    assign sof   = (hc == '0) && (vc == V_LAST);

    // Counters sit at 0,0 (an active position) while in reset; gating with reset_n keeps
    // ready/start_frame at their idle level for the whole reset window.
    assign ready       = reset_n & (act | drain);
    assign start_frame = reset_n & sof;

    assign video_width  = 16'(H_ACTIVE);
    assign video_height = 16'(V_ACTIVE);

    logic [LANES-1:0][PIX_W-1:0] lane_px;
    assign lane_px = {bits_3[PIX_W-1:0], bits_2[PIX_W-1:0], bits_1[PIX_W-1:0], bits_0[PIX_W-1:0]};

    // Upper lane bits carry no pixel data.
    logic unused_lane_bits;
    assign unused_lane_bits = ^{bits_0[LANE_W-1:PIX_W], bits_1[LANE_W-1:PIX_W],
                                bits_2[LANE_W-1:PIX_W], bits_3[LANE_W-1:PIX_W]};

    logic [LANES-1:0][PIX_W-1:0] pixel_q, pixel_d;
    logic                        de_q, de_d;
    logic                        hsync_q, hsync_d;
    logic                        vsync_q, vsync_d;
    logic                        underflow_q, underflow_d;
    logic [15:0]                 drop_q, drop_d;

    always_comb begin
        de_d        = act;
        hsync_d     = (h_region == REG_SYNC) ? HSYNC_POL : ~HSYNC_POL;
        vsync_d     = (v_region == REG_SYNC) ? VSYNC_POL : ~VSYNC_POL;
        pixel_d     = '0;
        underflow_d = underflow_q;
        drop_d      = drop_q;

        // Missing beats are replaced by black; the raster keeps running.
        if (act && valid) begin
            pixel_d = lane_px;
        end
        if (act && !valid) begin
            underflow_d = 1'b1;
        end
        if (drain && valid && (drop_q != 16'hFFFF)) begin
            drop_d = drop_q + 16'd1;
        end

        // Clear has priority over an event in the same cycle.
        if (clear_status) begin
            underflow_d = 1'b0;
            drop_d      = '0;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pixel_q     <= '0;
            de_q        <= 1'b0;
            hsync_q     <= ~HSYNC_POL;
            vsync_q     <= ~VSYNC_POL;
            underflow_q <= 1'b0;
            drop_q      <= '0;
        end else begin
            pixel_q     <= pixel_d;
            de_q        <= de_d;
            hsync_q     <= hsync_d;
            vsync_q     <= vsync_d;
            underflow_q <= underflow_d;
            drop_q      <= drop_d;
        end
    end

    assign pixel_0    = pixel_q[0];
    assign pixel_1    = pixel_q[1];
    assign pixel_2    = pixel_q[2];
    assign pixel_3    = pixel_q[3];
    assign de         = de_q;
    assign hsync      = hsync_q;
    assign vsync      = vsync_q;
    assign underflow  = underflow_q;
    assign drop_count = drop_q;

endmodule
